// File: rtl/sha_stream_pkg.sv
// Shared definitions for the SHA-256 stream blocks: FSM states, trailer layout
// and the helper that packs a digest into a full-width trailer beat.
package sha_stream_pkg;

  typedef enum logic [0:0] {
    STREAM   = 1'b0,
    WAIT_DIG = 1'b1
  } state_t;

  localparam int TDATA_W      = 512;
  localparam int TKEEP_W      = TDATA_W / 8;
  localparam int DIGEST_BYTES = 32;
  localparam int DIGEST_W     = DIGEST_BYTES * 8;

  // Only the low DIGEST_BYTES lanes of the trailer carry data.
  localparam logic [TKEEP_W-1:0] TRAILER_KEEP =
    {{(TKEEP_W - DIGEST_BYTES){1'b0}}, {DIGEST_BYTES{1'b1}}};

  function automatic logic [TDATA_W-1:0] pack_trailer(input logic [DIGEST_W-1:0] digest);
    return {{(TDATA_W - DIGEST_W){1'b0}}, digest};
  endfunction

endpackage

// File: rtl/append_sha_out_reg.sv
// Single-stage AXI-Stream output register; slot_free tells the producer that
// a new beat can be loaded this cycle (empty, or draining downstream now).
module append_sha_out_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [KEEP_W-1:0] d_keep,
  input  logic [ID_W-1:0]   d_id,
  input  logic              d_last,
  output logic [DATA_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic [ID_W-1:0]   tid,
  output logic              tlast,
  output logic              tvalid,
  input  logic              tready,
  output logic              slot_free
);

  assign slot_free = !tvalid || tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tkeep  <= '0;
      tid    <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= d_data;
      tkeep  <= d_keep;
      tid    <= d_id;
      tlast  <= d_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/append_sha.sv
// Forwards each outgoing packet while forking its beats to a SHA-256 engine,
// then appends the returned digest as a final tlast trailer beat.
module append_sha
  import sha_stream_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int ID_WIDTH         = 6,
  parameter int DIGEST_WIDTH     = 256
) (
  input  logic                          aclk,
  input  logic                          areset,

  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,

  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,

  output logic [AXIS_TDATA_WIDTH-1:0]   m_hash_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_hash_tkeep,
  output logic [ID_WIDTH-1:0]           m_hash_tid,
  output logic                          m_hash_tlast,
  output logic                          m_hash_tvalid,
  input  logic                          m_hash_tready,

  input  logic [DIGEST_WIDTH-1:0]       s_digest_tdata,
  input  logic                          s_digest_tvalid,
  output logic                          s_digest_tready,

  output logic [31:0]                   pkt_count,
  output logic                          busy
);

  localparam int KW = AXIS_TDATA_WIDTH / 8;

  state_t                        state;
  logic                          in_stream;
  logic                          slot_free;
  logic                          beat_acc;
  logic                          dig_acc;
  logic                          load;
  logic [15:0]                   beat_cnt;
  logic [ID_WIDTH-1:0]           pkt_id;
  logic [AXIS_TDATA_WIDTH-1:0]   ld_data;
  logic [KW-1:0]                 ld_keep;
  logic [ID_WIDTH-1:0]           ld_id;
  logic                          ld_last;

  assign in_stream = (state == STREAM);

  // The fork is lock-step: the input only moves when both the hash engine
  // and the output register can take the beat in the same cycle.
  assign s_axis_tready   = in_stream && m_hash_tready && slot_free;
  assign m_hash_tvalid   = in_stream && s_axis_tvalid && slot_free;
  assign m_hash_tdata    = s_axis_tdata;
  assign m_hash_tkeep    = s_axis_tkeep;
  assign m_hash_tid      = s_axis_tid;
  assign m_hash_tlast    = s_axis_tlast;

  assign s_digest_tready = !in_stream && slot_free;

  assign beat_acc = s_axis_tvalid && s_axis_tready;
  assign dig_acc  = s_digest_tvalid && s_digest_tready;
  assign load     = beat_acc || dig_acc;

  assign busy = !in_stream || m_axis_tvalid;

  // Payload beats go out with tlast cleared; only the trailer closes a packet.
  always_comb begin
    ld_data = s_axis_tdata;
    ld_keep = s_axis_tkeep;
    ld_id   = s_axis_tid;
    ld_last = 1'b0;
    if (dig_acc) begin
      ld_data = pack_trailer(s_digest_tdata);
      ld_keep = TRAILER_KEEP;
      ld_id   = pkt_id;
      ld_last = 1'b1;
    end
  end

  append_sha_out_reg #(
    .DATA_W (AXIS_TDATA_WIDTH),
    .KEEP_W (KW),
    .ID_W   (ID_WIDTH)
  ) u_out_reg (
    .clk       (aclk),
    .rst_n     (areset),
    .load      (load),
    .d_data    (ld_data),
    .d_keep    (ld_keep),
    .d_id      (ld_id),
    .d_last    (ld_last),
    .tdata     (m_axis_tdata),
    .tkeep     (m_axis_tkeep),
    .tid       (m_axis_tid),
    .tlast     (m_axis_tlast),
    .tvalid    (m_axis_tvalid),
    .tready    (m_axis_tready),
    .slot_free (slot_free)
  );

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state <= STREAM;
    end else begin
      case (state)
        STREAM:   if (beat_acc && s_axis_tlast) state <= WAIT_DIG;
        WAIT_DIG: if (dig_acc) state <= STREAM;
        default:  state <= STREAM;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      beat_cnt <= '0;
      pkt_id   <= '0;
    end else if (beat_acc) begin
      if (beat_cnt == 16'd0) pkt_id <= s_axis_tid;
      if (s_axis_tlast)
        beat_cnt <= '0;
      else if (beat_cnt != 16'hFFFF)
        beat_cnt <= beat_cnt + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset)
      pkt_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
      pkt_count <= pkt_count + 32'd1;
  end

endmodule
